// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ack handshake and
// hands them to the decoder, then steps the PC when the decoder consumes the word.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic [31:0] IMEM_ADR,
    output logic        IMEM_REQ,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_DATA,
    output logic [31:0] MEM_INST,
    output logic        INST_ENB,
    input  logic        PC_CLK,
    input  logic [2:0]  PC_MUX_SELECT,
    input  logic [31:0] IMM,
    input  logic [31:0] TARGET,
    output logic [31:0] PC_ADDR,
    output logic        MISALIGN
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] nxt_pc;
    logic        nxt_aligned;

    // Next-PC mux; bit0 of the jump target is dropped before the alignment test.
    always_comb begin
        pc_plus4 = pc + 32'd4;
        nxt_pc   = pc_plus4;
        case (PC_MUX_SELECT)
            3'd1:    nxt_pc = pc + IMM;
            3'd2:    nxt_pc = {TARGET[31:1], 1'b0};
            default: nxt_pc = pc_plus4;
        endcase
        nxt_aligned = (nxt_pc[1:0] == 2'b00);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            pc       <= RESET_PC;
            IMEM_REQ <= 1'b0;
            INST_ENB <= 1'b0;
            MEM_INST <= NOP_INST;
            MISALIGN <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    IMEM_REQ <= 1'b1;
                    state    <= ST_REQ;
                end
                ST_REQ: begin
                    if (IMEM_ACK) begin
                        MEM_INST <= IMEM_DATA;
                        IMEM_REQ <= 1'b0;
                        INST_ENB <= 1'b1;
                        state    <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (PC_CLK) begin
                        INST_ENB <= 1'b0;
                        MEM_INST <= NOP_INST;
                        pc       <= nxt_pc;
                        if (nxt_aligned) begin
                            IMEM_REQ <= 1'b1;
                            state    <= ST_REQ;
                        end else begin
                            MISALIGN <= 1'b1;
                            state    <= ST_HALT;
                        end
                    end
                end
                default: begin
                    // Sticky fault; only reset leaves this state.
                    IMEM_REQ <= 1'b0;
                    INST_ENB <= 1'b0;
                    MISALIGN <= 1'b1;
                end
            endcase
        end
    end

    assign IMEM_ADR = pc;
    assign PC_ADDR  = pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: sequential fetch, wait states, redirects,
// misalign halt and reset while a request is outstanding.
module tb_inst_fetch;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] IMEM_ADR;
    logic        IMEM_REQ;
    logic        IMEM_ACK;
    logic [31:0] IMEM_DATA;
    logic [31:0] MEM_INST;
    logic        INST_ENB;
    logic        PC_CLK;
    logic [2:0]  PC_MUX_SELECT;
    logic [31:0] IMM;
    logic [31:0] TARGET;
    logic [31:0] PC_ADDR;
    logic        MISALIGN;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    inst_fetch dut (
        .CLK(CLK), .RST_N(RST_N),
        .IMEM_ADR(IMEM_ADR), .IMEM_REQ(IMEM_REQ), .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA),
        .MEM_INST(MEM_INST), .INST_ENB(INST_ENB), .PC_CLK(PC_CLK),
        .PC_MUX_SELECT(PC_MUX_SELECT), .IMM(IMM), .TARGET(TARGET),
        .PC_ADDR(PC_ADDR), .MISALIGN(MISALIGN)
    );

    // Small instruction memory: a few real words, address-derived filler elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h00500093;
            32'h4:   return 32'h00A00113;
            32'h8:   return 32'h002081B3;
            default: return a ^ 32'h00000013;
        endcase
    endfunction

    assign IMEM_DATA = mem_word(IMEM_ADR);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    initial begin
        RST_N = 1'b0; IMEM_ACK = 1'b0; PC_CLK = 1'b0;
        PC_MUX_SELECT = 3'd0; IMM = 32'h0; TARGET = 32'h0;
        step(); step();
        chk("rst_req",  {31'b0, IMEM_REQ}, 32'd0);
        chk("rst_enb",  {31'b0, INST_ENB}, 32'd0);
        chk("rst_inst", MEM_INST, 32'h00000013);
        chk("rst_pc",   PC_ADDR, 32'h0);
        chk("rst_mis",  {31'b0, MISALIGN}, 32'd0);

        // Zero-wait sequential fetch.
        RST_N = 1'b1; IMEM_ACK = 1'b1; PC_CLK = 1'b1;
        step();
        chk("zw_req0", {31'b0, IMEM_REQ}, 32'd1);
        chk("zw_adr0", IMEM_ADR, 32'h0);
        chk("zw_enb0", {31'b0, INST_ENB}, 32'd0);
        step();
        chk("zw_enb1",  {31'b0, INST_ENB}, 32'd1);
        chk("zw_inst0", MEM_INST, 32'h00500093);
        chk("zw_reqlo", {31'b0, IMEM_REQ}, 32'd0);
        step();
        chk("zw_adr4",  IMEM_ADR, 32'h4);
        chk("zw_enb2",  {31'b0, INST_ENB}, 32'd0);
        chk("zw_nop",   MEM_INST, 32'h00000013);
        step();
        chk("zw_inst4", MEM_INST, 32'h00A00113);
        step();
        chk("zw_adr8",  IMEM_ADR, 32'h8);
        step();
        chk("zw_inst8", MEM_INST, 32'h002081B3);
        chk("zw_pc8",   PC_ADDR, 32'h8);

        // Branch back: 0x8 + (-8) = 0x0.
        IMEM_ACK = 1'b0; PC_MUX_SELECT = 3'd1; IMM = 32'hFFFFFFF8;
        step();
        chk("br_adr", IMEM_ADR, 32'h0);
        chk("br_req", {31'b0, IMEM_REQ}, 32'd1);
        PC_CLK = 1'b0; PC_MUX_SELECT = 3'd0;

        // Three wait states on the memory side.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ws_req", {31'b0, IMEM_REQ}, 32'd1);
            chk("ws_adr", IMEM_ADR, 32'h0);
            chk("ws_enb", {31'b0, INST_ENB}, 32'd0);
        end
        IMEM_ACK = 1'b1;
        step();
        chk("ws_enb_up", {31'b0, INST_ENB}, 32'd1);
        chk("ws_inst",   MEM_INST, 32'h00500093);

        // Decoder stall; a stray ACK must not disturb the held word.
        for (int i = 0; i < 5; i++) begin
            IMEM_ACK = (i == 2);
            step();
            chk("st_inst", MEM_INST, 32'h00500093);
            chk("st_pc",   PC_ADDR, 32'h0);
            chk("st_enb",  {31'b0, INST_ENB}, 32'd1);
        end
        IMEM_ACK = 1'b0;

        // Jump with bit0 set in target: 0x101 -> 0x100.
        PC_MUX_SELECT = 3'd2; TARGET = 32'h00000101; PC_CLK = 1'b1;
        step();
        chk("jr_adr", IMEM_ADR, 32'h100);
        chk("jr_req", {31'b0, IMEM_REQ}, 32'd1);
        chk("jr_mis", {31'b0, MISALIGN}, 32'd0);
        PC_CLK = 1'b0; IMEM_ACK = 1'b1;
        step();
        chk("jr_inst", MEM_INST, 32'h00000113);
        chk("jr_pc",   PC_ADDR, 32'h100);

        // Wrap: 0xFFFFFFFC + 4 = 0x0 without fault.
        IMEM_ACK = 1'b0; TARGET = 32'hFFFFFFFD; PC_CLK = 1'b1;
        step();
        chk("wr_adr_top", IMEM_ADR, 32'hFFFFFFFC);
        PC_CLK = 1'b0; IMEM_ACK = 1'b1;
        step();
        chk("wr_enb", {31'b0, INST_ENB}, 32'd1);
        IMEM_ACK = 1'b0; PC_MUX_SELECT = 3'd0; PC_CLK = 1'b1;
        step();
        chk("wr_adr0", IMEM_ADR, 32'h0);
        chk("wr_mis",  {31'b0, MISALIGN}, 32'd0);
        chk("wr_req",  {31'b0, IMEM_REQ}, 32'd1);

        // Reach PC 0x4 then branch by +2.
        PC_CLK = 1'b0; IMEM_ACK = 1'b1;
        step();
        IMEM_ACK = 1'b0; PC_CLK = 1'b1;
        step();
        chk("ma_adr4", IMEM_ADR, 32'h4);
        PC_CLK = 1'b0; IMEM_ACK = 1'b1;
        step();
        chk("ma_pc4", PC_ADDR, 32'h4);
        IMEM_ACK = 1'b0; PC_MUX_SELECT = 3'd1; IMM = 32'h2; PC_CLK = 1'b1;
        step();
        chk("ma_mis", {31'b0, MISALIGN}, 32'd1);
        chk("ma_pc",  PC_ADDR, 32'h6);
        chk("ma_req", {31'b0, IMEM_REQ}, 32'd0);
        chk("ma_enb", {31'b0, INST_ENB}, 32'd0);
        IMEM_ACK = 1'b1; PC_MUX_SELECT = 3'd0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt_req", {31'b0, IMEM_REQ}, 32'd0);
            chk("halt_mis", {31'b0, MISALIGN}, 32'd1);
            chk("halt_pc",  PC_ADDR, 32'h6);
        end

        // Asynchronous reset clears the fault mid-cycle.
        IMEM_ACK = 1'b0; PC_CLK = 1'b0;
        @(posedge CLK); #2;
        RST_N = 1'b0;
        #1;
        chk("ar_mis",  {31'b0, MISALIGN}, 32'd0);
        chk("ar_pc",   PC_ADDR, 32'h0);
        chk("ar_inst", MEM_INST, 32'h00000013);
        chk("ar_enb",  {31'b0, INST_ENB}, 32'd0);
        step();
        RST_N = 1'b1;
        step();
        chk("rs_req0", {31'b0, IMEM_REQ}, 32'd1);
        IMEM_ACK = 1'b1;
        step();
        IMEM_ACK = 1'b0; PC_MUX_SELECT = 3'd2; TARGET = 32'h10; PC_CLK = 1'b1;
        step();
        chk("rq_adr", IMEM_ADR, 32'h10);
        PC_CLK = 1'b0;
        step();
        chk("rq_wait", {31'b0, IMEM_REQ}, 32'd1);

        // Reset while the request to 0x10 is outstanding.
        @(posedge CLK); #2;
        RST_N = 1'b0;
        #1;
        chk("rq_drop", {31'b0, IMEM_REQ}, 32'd0);
        chk("rq_adr0", IMEM_ADR, 32'h0);
        IMEM_ACK = 1'b1;
        step(); step();
        chk("rq_enb",  {31'b0, INST_ENB}, 32'd0);
        chk("rq_inst", MEM_INST, 32'h00000013);
        IMEM_ACK = 1'b0; RST_N = 1'b1;
        step();
        chk("rq_first_adr", IMEM_ADR, 32'h0);
        chk("rq_first_req", {31'b0, IMEM_REQ}, 32'd1);
        IMEM_ACK = 1'b1;
        step();
        chk("rq_first_inst", MEM_INST, 32'h00500093);
        chk("rq_first_enb",  {31'b0, INST_ENB}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch unit. It is the supplier end of the decoder's MEM_INST / INST_ENB / PC_CLK interface.
- Owns the program counter.
- Issues word reads to instruction memory over a req/ack handshake.
- Presents each fetched instruction to the control unit.
- Computes the next PC from the decoder's PC_MUX_SELECT once the decoder signals consumption via PC_CLK.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset; must be 4-byte aligned.
NOP_INST, 32'h00000013, value driven on MEM_INST while no instruction is valid (ADDI x0,x0,0).

Ports:
CLK  input  1  system clock; all state changes on rising edge.
RST_N  input  1  asynchronous, active-low reset.
IMEM_ADR  output  32  instruction memory byte address; always equals the internal PC.
IMEM_REQ  output  1  read request to instruction memory.
IMEM_ACK  input  1  memory has IMEM_DATA valid; sampled on CLK rising edge.
IMEM_DATA  input  32  instruction word from memory.
MEM_INST  output  32  instruction presented to the decoder.
INST_ENB  output  1  MEM_INST is valid.
PC_CLK  input  1  decoder-consumed strobe; sampled on CLK rising edge.
PC_MUX_SELECT  input  3  next-PC source. 0: PC+4. 1: PC+IMM. 2: TARGET with bit0 cleared. 3-7: PC+4.
IMM  input  32  sign-extended PC-relative offset.
TARGET  input  32  absolute jump target (JALR result).
PC_ADDR  output  32  PC of the instruction on MEM_INST.
MISALIGN  output  1  sticky misaligned-next-PC fault.

Behaviour:
- Reset (RST_N=0, asynchronous) sets:
  - PC = RESET_PC; IMEM_ADR = PC_ADDR = RESET_PC.
  - IMEM_REQ = 0, INST_ENB = 0, MISALIGN = 0.
  - MEM_INST = NOP_INST; state = IDLE.
- All outputs are registered. Outputs change only on CLK rising edges, except during asynchronous reset.
- States: IDLE, REQ, VALID, HALT.
- IDLE: the first edge after RST_N deasserts goes to REQ, with IMEM_REQ=1.
- REQ:
  - IMEM_REQ=1 and IMEM_ADR are held stable until IMEM_ACK=1 is sampled.
  - On that edge: MEM_INST <= IMEM_DATA, IMEM_REQ <= 0, INST_ENB <= 1, state = VALID.
  - Any number of wait cycles is permitted.
- VALID:
  - MEM_INST, INST_ENB and PC_ADDR are held stable until PC_CLK=1 is sampled.
  - On that edge the next PC is computed from PC_MUX_SELECT, IMM and TARGET sampled on the same edge.
  - Then: INST_ENB <= 0, MEM_INST <= NOP_INST, PC/IMEM_ADR/PC_ADDR <= next PC.
  - If next PC[1:0]==0: IMEM_REQ <= 1, state = REQ.
  - Otherwise: state = HALT.
- HALT:
  - MISALIGN=1, IMEM_REQ=0, INST_ENB=0.
  - PC_ADDR holds the offending address.
  - Exit only by reset.
- Arithmetic: 32-bit unsigned add, wrapping modulo 2^32 (0xFFFFFFFC+4 = 0x00000000, no fault). Select 2 clears bit0 before the alignment check.
- Ignored inputs:
  - IMEM_ACK outside REQ.
  - PC_CLK outside VALID.
  - IMEM_DATA outside the ACK edge.
- Minimum cadence is 2 cycles per instruction: the ACK edge, then the PC_CLK edge.
- Reset mid-REQ: the outstanding request is abandoned immediately and the late ACK is ignored. Fetch restarts from RESET_PC via IDLE.

Test Plan:
1. Reset: hold RST_N=0 mid-stream -> IMEM_REQ=0, INST_ENB=0, MEM_INST=0x00000013, PC_ADDR=0x0, MISALIGN=0 asynchronously.
2. Zero-wait sequential fetch: IMEM_ACK tied 1, PC_CLK=1 whenever INST_ENB, select 0 -> IMEM_ADR 0x0,0x4,0x8. INST_ENB high every other cycle. MEM_INST matches memory words (e.g. 0x00500093).
3. Wait states: ACK delayed 3 cycles -> IMEM_REQ/IMEM_ADR stable for all 3. INST_ENB rises on the edge after ACK. Decoder stalls PC_CLK=0 for 5 cycles -> MEM_INST/PC_ADDR unchanged.
4. Redirects:
   - At PC 0x8, select 1, IMM=0xFFFFFFF8 -> next IMEM_ADR 0x0.
   - Select 2, TARGET=0x00000101 -> 0x100.
   - At PC 0xFFFFFFFC, select 0 -> 0x0, no fault.
5. Misalign: at PC 0x4, select 1, IMM=0x2 -> MISALIGN=1, PC_ADDR=0x6. IMEM_REQ stays 0 for 10 cycles despite PC_CLK/ACK activity, and clears only on reset.
6. Reset during REQ: assert RST_N=0 while waiting on ACK at 0x10 -> IMEM_REQ drops immediately. An ACK during reset is ignored. After release, the first request is to 0x0.
